// File: rtl/and16_result_checker.sv
// and16_result_checker: recomputes in0 & in1 for each accepted triple, compares against dut_out,
// counts passes/fails with saturation and captures the first mismatch.
module and16_result_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] dut_out,
  input  logic             last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic [WIDTH-1:0] first_fail_got
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           r_state, w_next;
  logic             r_s1_v;
  logic [WIDTH-1:0] r_exp, r_got;
  logic [CNT_W-1:0] r_idx, r_vec_idx;
  logic             w_acc, w_clr, w_match;
  assign vec_ready = r_state == RUN;
  assign busy      = r_state == RUN || r_state == DRAIN;
  assign done      = r_state == DONE;
  assign w_acc     = vec_valid & vec_ready;
  assign w_clr     = start & (r_state == IDLE || r_state == DONE);
  assign w_match   = r_exp == r_got;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE || r_state == DONE) ? (start ? RUN : r_state) :
             (r_state == RUN) ? ((w_acc && last) ? DRAIN : RUN) : DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_s1_v         <= 1'b0;
      r_exp          <= '0;
      r_got          <= '0;
      r_idx          <= '0;
      r_vec_idx      <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      err_sticky     <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
    end else begin
      r_state <= w_next;
      r_s1_v  <= w_acc;
      if (w_acc) begin
        r_exp     <= in0 & in1;
        r_got     <= dut_out;
        r_idx     <= r_vec_idx;
        r_vec_idx <= r_vec_idx + CNT_W'(1);
      end
      // clear and stage-2 never coincide: stage 2 is empty in IDLE/DONE
      if (w_clr) begin
        r_vec_idx      <= '0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        err_sticky     <= 1'b0;
        first_fail_idx <= '0;
        first_fail_exp <= '0;
        first_fail_got <= '0;
      end else if (r_s1_v) begin
        if (w_match) pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
        else begin
          fail_cnt <= fail_cnt + CNT_W'(fail_cnt != '1);
          if (!err_sticky) begin
            err_sticky     <= 1'b1;
            first_fail_idx <= r_idx;
            first_fail_exp <= r_exp;
            first_fail_got <= r_got;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_and16_result_checker.sv
// tb_and16_result_checker: directed table-driven checks of the AND16 result checker,
// plus hand-written handshake, restart and counter-saturation sequences.
module tb_and16_result_checker;
  logic        clk = 1'b0;
  logic        rst_n, start, vec_valid, last, start2, valid2;
  logic [15:0] in0, in1, dut_out;
  logic        vec_ready, busy, done, err_sticky;
  logic [15:0] pass_cnt, fail_cnt, first_fail_idx, first_fail_exp, first_fail_got;
  logic        s_ready, s_busy, s_done, s_err;
  logic [3:0]  s_pass, s_fail, s_idx;
  logic [15:0] s_exp, s_got;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  and16_result_checker #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .in0(in0), .in1(in1), .dut_out(dut_out), .last(last), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_sticky(err_sticky),
    .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got));

  and16_result_checker #(.WIDTH(16), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_valid(valid2), .vec_ready(s_ready),
    .in0(in0), .in1(in1), .dut_out(dut_out), .last(last), .busy(s_busy), .done(s_done),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .err_sticky(s_err),
    .first_fail_idx(s_idx), .first_fail_exp(s_exp), .first_fail_got(s_got));

  typedef struct {
    logic [15:0] a, b, o;
    logic        l;
    logic [15:0] p, f;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // back-to-back vectors; counters lag acceptance by one edge
  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      if (i - lo >= 2) begin
        chk("pass_lag", pass_cnt, tbl[i-2].p);
        chk("fail_lag", fail_cnt, tbl[i-2].f);
      end
      vec_valid = 1'b1; in0 = tbl[i].a; in1 = tbl[i].b; dut_out = tbl[i].o; last = tbl[i].l;
    end
    @(negedge clk);
    vec_valid = 1'b0; last = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    chk("drain_pass", pass_cnt, tbl[hi-1].p);
    @(negedge clk);
    chk("done", done, 1);
    chk("final_pass", pass_cnt, tbl[hi].p);
    chk("final_fail", fail_cnt, tbl[hi].f);
  endtask

  initial begin
    tbl[0] = '{16'h02F3, 16'h0000, 16'h0000, 1'b0, 16'd1, 16'd0};
    tbl[1] = '{16'h02F3, 16'hFFFF, 16'h02F3, 1'b0, 16'd2, 16'd0};
    tbl[2] = '{16'h02F3, 16'h0000, 16'h0000, 1'b1, 16'd3, 16'd0};
    tbl[3] = '{16'h1234, 16'h00FF, 16'h0034, 1'b0, 16'd1, 16'd0};
    tbl[4] = '{16'hAAAA, 16'h5555, 16'h0000, 1'b0, 16'd2, 16'd0};
    tbl[5] = '{16'h02F3, 16'hFFFF, 16'h02F2, 1'b0, 16'd2, 16'd1};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16'd2, 16'd2};
    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; last = 1'b0; start2 = 1'b0; valid2 = 1'b0;
    in0 = '0; in1 = '0; dut_out = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", vec_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0);
    rst_n = 1'b1;
    // reset in the middle of a run with three vectors accepted
    pulse_start();
    chk("run_ready", vec_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_valid = 1'b1; in0 = 16'h00FF; in1 = 16'h0F0F; dut_out = 16'h000F;
    end
    @(negedge clk);
    chk("pre_rst_pass", pass_cnt, 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_ready", vec_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pass", pass_cnt, 0);
    chk("mid_rst_fail", fail_cnt, 0);
    rst_n = 1'b1; vec_valid = 1'b0;
    pulse_start();
    run_table(0, 2);
    chk("pass_run_err", err_sticky, 0);
    pulse_start();
    run_table(3, 6);
    chk("ff_err", err_sticky, 1);
    chk("ff_idx", first_fail_idx, 2);
    chk("ff_exp", first_fail_exp, 16'h02F3);
    chk("ff_got", first_fail_got, 16'h02F2);
    // restart from DONE clears everything at the same edge
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("rs_pass", pass_cnt, 0);
    chk("rs_fail", fail_cnt, 0);
    chk("rs_err", err_sticky, 0);
    chk("rs_idx", first_fail_idx, 0);
    chk("rs_exp", first_fail_exp, 0);
    chk("rs_got", first_fail_got, 0);
    chk("rs_busy", busy, 1);
    chk("rs_ready", vec_ready, 1);
    // handshake gaps, ignored start, last without valid, vectors offered after the run
    vec_valid = 1'b1; in0 = 16'h000F; in1 = 16'h00F0; dut_out = 16'h0000;
    @(negedge clk) vec_valid = 1'b0; last = 1'b1; dut_out = 16'h5555;
    @(negedge clk) start = 1'b1; last = 1'b0;
    @(negedge clk) start = 1'b0;
    chk("hs_busy", busy, 1);
    chk("hs_pass", pass_cnt, 1);
    vec_valid = 1'b1; in0 = 16'hFF00; in1 = 16'h0FF0; dut_out = 16'h0F00;
    @(negedge clk) start = 1'b1; in0 = 16'h0001; in1 = 16'h0001; dut_out = 16'h0000; last = 1'b1;
    @(negedge clk) start = 1'b0; in0 = 16'hFFFF; in1 = 16'hFFFF; last = 1'b0;
    chk("hs_drain_busy", busy, 1);
    chk("hs_drain_done", done, 0);
    chk("hs_drain_pass", pass_cnt, 2);
    @(negedge clk);
    chk("hs_done", done, 1);
    chk("hs_pass2", pass_cnt, 2);
    chk("hs_fail", fail_cnt, 1);
    chk("hs_ff_idx", first_fail_idx, 2);
    chk("hs_ff_exp", first_fail_exp, 16'h0001);
    @(negedge clk);
    chk("hs_done_pass", pass_cnt, 2);
    chk("hs_done_fail", fail_cnt, 1);
    vec_valid = 1'b0;
    // narrow counters: saturation and index wrap
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid2 = 1'b1; in0 = 16'(i * 37); in1 = 16'hFFFF; dut_out = 16'(i * 37); last = 1'b0;
    end
    @(negedge clk) in0 = 16'h00F0; in1 = 16'h00FF; dut_out = 16'h0000; last = 1'b1;
    @(negedge clk) valid2 = 1'b0; last = 1'b0;
    @(negedge clk);
    chk("sat_done", s_done, 1);
    chk("sat_pass", s_pass, 15);
    chk("sat_fail", s_fail, 1);
    chk("sat_idx_wrap", s_idx, 4);
    chk("sat_exp", s_exp, 16'h00F0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
